// File: rtl/resc_sched_pkg.sv
// Shared types and constants for the ReSC job scheduler.
// Provides the FSM state enum, ARM window length, default timeout, width helper.
package resc_sched_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_ARM,
        S_RUN,
        S_RESP
    } sched_state_t;

    localparam int unsigned ARM_CYCLES  = 2;
    localparam int unsigned TIMEOUT_DEF = 1040;

    // Bits needed to hold 0..v-1, never less than 1.
    function automatic int unsigned clog2_w(input int unsigned v);
        int unsigned r;
        r = 1;
        while ((64'd1 << r) < 64'(v)) r++;
        return r;
    endfunction

endpackage

// File: rtl/resc_rr_arbiter.sv
// Combinational round-robin pick: first set req bit at/after ptr, wrapping.
// Ports: req, ptr in; one-hot grant, binary idx, any out.
module resc_rr_arbiter #(
    parameter int N  = 4,
    parameter int PW = 2
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  grant,
    output logic [PW-1:0] idx,
    output logic          any
);

    logic found;
    int   j;

    always_comb begin
        grant = '0;
        idx   = '0;
        found = 1'b0;
        j     = 0;
        for (int k = 0; k < N; k++) begin
            j = (int'(ptr) + k) % N;
            if (!found && req[j]) begin
                found    = 1'b1;
                grant[j] = 1'b1;
                idx      = PW'(j);
            end
        end
    end

    assign any = |req;

endmodule

// File: rtl/resc_job_scheduler.sv
// Shares one ReSC wrapper among N_REQ requesters: RR grant, start, ARM, RUN, RESP.
// Ports: req_valid/req_x/req_ready, resp_valid/resp_y/resp_err, busy, resc_* wrapper side.
module resc_job_scheduler
    import resc_sched_pkg::*;
#(
    parameter int unsigned N_REQ   = 4,
    parameter int unsigned X_WIDTH = 6,
    parameter int unsigned Y_WIDTH = 10,
    parameter int unsigned TIMEOUT = TIMEOUT_DEF
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic [N_REQ-1:0]           req_valid,
    input  logic [N_REQ*X_WIDTH-1:0]   req_x,
    output logic [N_REQ-1:0]           req_ready,
    output logic [N_REQ-1:0]           resp_valid,
    output logic [Y_WIDTH-1:0]         resp_y,
    output logic                       resp_err,
    output logic                       busy,
    output logic [X_WIDTH-1:0]         resc_x_bin,
    output logic                       resc_start,
    input  logic                       resc_done,
    input  logic [Y_WIDTH-1:0]         resc_y_bin
);

    localparam int unsigned PW = clog2_w(N_REQ);
    localparam int unsigned CW = clog2_w(TIMEOUT + 1);

    localparam logic [CW-1:0] ARM_LAST = CW'(ARM_CYCLES - 1);
    localparam logic [CW-1:0] TO_CNT   = CW'(TIMEOUT);
    localparam logic [PW-1:0] LAST_IDX = PW'(N_REQ - 1);

    sched_state_t       state;
    sched_state_t       state_nx;
    logic [PW-1:0]      ptr;
    logic [PW-1:0]      gidx;
    logic [PW-1:0]      arb_idx;
    logic [N_REQ-1:0]   arb_grant;
    logic               arb_any;
    logic [X_WIDTH-1:0] x_q;
    logic [CW-1:0]      cnt;
    logic [Y_WIDTH-1:0] y_q;
    logic               err_q;
    logic               run_done;
    logic               run_tmo;

    resc_rr_arbiter #(
        .N  (N_REQ),
        .PW (PW)
    ) u_arb (
        .req   (req_valid),
        .ptr   (ptr),
        .grant (arb_grant),
        .idx   (arb_idx),
        .any   (arb_any)
    );

    // done takes priority over an expiring counter
    assign run_done = (state == S_RUN) && resc_done;
    assign run_tmo  = (state == S_RUN) && !resc_done && (cnt == TO_CNT);

    assign resc_x_bin = x_q;

    always_comb begin
        state_nx   = state;
        req_ready  = '0;
        resp_valid = '0;
        resp_y     = '0;
        resp_err   = 1'b0;
        resc_start = 1'b0;
        busy       = (state != S_IDLE);
        unique case (state)
            S_IDLE: begin
                // gated so no grant pulse escapes while held in reset
                if (reset_n) req_ready = arb_grant;
                if (arb_any) state_nx = S_START;
            end
            S_START: begin
                resc_start = 1'b1;
                state_nx   = S_ARM;
            end
            S_ARM: begin
                if (cnt == ARM_LAST) state_nx = S_RUN;
            end
            S_RUN: begin
                if (run_done || run_tmo) state_nx = S_RESP;
            end
            S_RESP: begin
                resp_valid[gidx] = 1'b1;
                resp_y           = y_q;
                resp_err         = err_q;
                state_nx         = S_IDLE;
            end
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= S_IDLE;
            ptr   <= '0;
            gidx  <= '0;
            x_q   <= '0;
            cnt   <= '0;
            y_q   <= '0;
            err_q <= 1'b0;
        end else begin
            state <= state_nx;
            unique case (state)
                S_IDLE: begin
                    if (arb_any) begin
                        gidx <= arb_idx;
                        x_q  <= req_x[int'(arb_idx)*X_WIDTH +: X_WIDTH];
                        ptr  <= (arb_idx == LAST_IDX) ? '0 : arb_idx + 1'b1;
                    end
                end
                S_START: cnt <= '0;
                S_ARM: cnt <= (cnt == ARM_LAST) ? '0 : cnt + 1'b1;
                S_RUN: begin
                    cnt <= cnt + 1'b1;
                    if (resc_done) begin
                        y_q   <= resc_y_bin;
                        err_q <= 1'b0;
                    end else if (run_tmo) begin
                        y_q   <= '0;
                        err_q <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
